// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Mode encodings, default 640x480 timing and width helpers
//                shared by the VGA mode controller files.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int MODE_BLACK = 0;
    localparam int MODE_SRC0  = 1;

    localparam int c_DEF_H_DISP   = 640;
    localparam int c_DEF_H_FPORCH = 16;
    localparam int c_DEF_H_SYNC   = 96;
    localparam int c_DEF_H_BPORCH = 48;
    localparam int c_DEF_V_DISP   = 480;
    localparam int c_DEF_V_FPORCH = 10;
    localparam int c_DEF_V_SYNC   = 2;
    localparam int c_DEF_V_BPORCH = 33;

    // Room for black, every source and at least one white code.
    function automatic int mode_width(input int n_src);
        return $clog2(n_src + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_mode_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_mode_ctrl_if
//  Description : Mode request, source pixel data and video output bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_mode_ctrl_if #(
    parameter int PIX_WIDTH = 12,
    parameter int COLOR_W   = 1,
    parameter int N_SRC     = 2
);
    import vga_pkg::*;

    localparam int MODE_W = mode_width(N_SRC);

    logic [MODE_W-1:0]            mode_i;
    logic [N_SRC*3*COLOR_W-1:0]   src_data_i;
    logic [PIX_WIDTH-1:0]         pix_x_o;
    logic [PIX_WIDTH-1:0]         pix_y_o;
    logic                         pix_de_o;
    logic                         frame_start_o;
    logic                         vga_hs_o;
    logic                         vga_vs_o;
    logic [COLOR_W-1:0]           vga_r_o;
    logic [COLOR_W-1:0]           vga_g_o;
    logic [COLOR_W-1:0]           vga_b_o;
    logic [MODE_W-1:0]            active_mode_o;
    logic [15:0]                  frame_cnt_o;

    modport master (
        input  mode_i, src_data_i,
        output pix_x_o, pix_y_o, pix_de_o, frame_start_o,
               vga_hs_o, vga_vs_o, vga_r_o, vga_g_o, vga_b_o,
               active_mode_o, frame_cnt_o
    );

    modport slave (
        output mode_i, src_data_i,
        input  pix_x_o, pix_y_o, pix_de_o, frame_start_o,
               vga_hs_o, vga_vs_o, vga_r_o, vga_g_o, vga_b_o,
               active_mode_o, frame_cnt_o
    );

endinterface
`default_nettype wire

// File: rtl/vga_timing_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_cnt
//  Description : Horizontal/vertical counters with raw display-enable and
//                sync-active flags decoded from the current count.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_cnt #(
    parameter int PIX_WIDTH = 12,
    parameter int H_DISP    = 640,
    parameter int H_FPORCH  = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BPORCH  = 48,
    parameter int V_DISP    = 480,
    parameter int V_FPORCH  = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BPORCH  = 33
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_i,
    output logic [PIX_WIDTH-1:0]      o_h_cnt,
    output logic [PIX_WIDTH-1:0]      o_v_cnt,
    output logic                      o_de,
    output logic                      o_hs_act,
    output logic                      o_vs_act,
    output logic                      o_frame_start,
    output logic                      o_frame_end
);

    localparam int c_H_TOTAL = H_DISP + H_FPORCH + H_SYNC + H_BPORCH;
    localparam int c_V_TOTAL = V_DISP + V_FPORCH + V_SYNC + V_BPORCH;

    localparam logic [PIX_WIDTH-1:0] c_H_LAST  = PIX_WIDTH'(c_H_TOTAL - 1);
    localparam logic [PIX_WIDTH-1:0] c_V_LAST  = PIX_WIDTH'(c_V_TOTAL - 1);
    localparam logic [PIX_WIDTH-1:0] c_H_VIS   = PIX_WIDTH'(H_DISP);
    localparam logic [PIX_WIDTH-1:0] c_V_VIS   = PIX_WIDTH'(V_DISP);
    localparam logic [PIX_WIDTH-1:0] c_HS_BEG  = PIX_WIDTH'(H_DISP + H_FPORCH);
    localparam logic [PIX_WIDTH-1:0] c_HS_END  = PIX_WIDTH'(H_DISP + H_FPORCH + H_SYNC);
    localparam logic [PIX_WIDTH-1:0] c_VS_BEG  = PIX_WIDTH'(V_DISP + V_FPORCH);
    localparam logic [PIX_WIDTH-1:0] c_VS_END  = PIX_WIDTH'(V_DISP + V_FPORCH + V_SYNC);

    logic [PIX_WIDTH-1:0] r_h_cnt;
    logic [PIX_WIDTH-1:0] r_v_cnt;
    logic                 w_h_last;
    logic                 w_v_last;

    assign w_h_last = (r_h_cnt == c_H_LAST);
    assign w_v_last = (r_v_cnt == c_V_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + PIX_WIDTH'(1);
        end else begin
            r_h_cnt <= r_h_cnt + PIX_WIDTH'(1);
        end
    end

    assign o_h_cnt       = r_h_cnt;
    assign o_v_cnt       = r_v_cnt;
    assign o_de          = (r_h_cnt < c_H_VIS) && (r_v_cnt < c_V_VIS);
    assign o_hs_act      = (r_h_cnt >= c_HS_BEG) && (r_h_cnt < c_HS_END);
    assign o_vs_act      = (r_v_cnt >= c_VS_BEG) && (r_v_cnt < c_VS_END);
    assign o_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign o_frame_end   = w_h_last && w_v_last;

endmodule
`default_nettype wire

// File: rtl/vga_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vga_mode_ctrl
//  Description : VGA timing with per-frame mode latch, source-latency delay
//                line and registered black/source/white pixel select.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_mode_ctrl
    import vga_pkg::*;
#(
    parameter int PIX_WIDTH = 12,
    parameter int COLOR_W   = 1,
    parameter int N_SRC     = 2,
    parameter int SRC_LAT   = 2,
    parameter int H_DISP    = c_DEF_H_DISP,
    parameter int H_FPORCH  = c_DEF_H_FPORCH,
    parameter int H_SYNC    = c_DEF_H_SYNC,
    parameter int H_BPORCH  = c_DEF_H_BPORCH,
    parameter int V_DISP    = c_DEF_V_DISP,
    parameter int V_FPORCH  = c_DEF_V_FPORCH,
    parameter int V_SYNC    = c_DEF_V_SYNC,
    parameter int V_BPORCH  = c_DEF_V_BPORCH,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    vga_mode_ctrl_if.master    bus
);

    localparam int MODE_W     = mode_width(N_SRC);
    localparam int c_PIX_BITS = 3 * COLOR_W;

    // Sync flags travel as "active" bits so a cleared stage reads inactive.
    typedef struct packed {
        logic              de;
        logic              hs;
        logic              vs;
        logic [MODE_W-1:0] mode;
    } stage_t;

    logic [PIX_WIDTH-1:0]  w_h_cnt;
    logic [PIX_WIDTH-1:0]  w_v_cnt;
    logic                  w_de;
    logic                  w_hs_act;
    logic                  w_vs_act;
    logic                  w_frame_start;
    logic                  w_frame_end;
    logic [MODE_W-1:0]     r_active_mode;
    logic [15:0]           r_frame_cnt;
    stage_t                w_raw;
    stage_t                w_dly;
    logic [c_PIX_BITS-1:0] w_pix;
    logic [c_PIX_BITS-1:0] r_rgb;
    logic                  r_hs;
    logic                  r_vs;

    vga_timing_cnt #(
        .PIX_WIDTH (PIX_WIDTH),
        .H_DISP    (H_DISP),
        .H_FPORCH  (H_FPORCH),
        .H_SYNC    (H_SYNC),
        .H_BPORCH  (H_BPORCH),
        .V_DISP    (V_DISP),
        .V_FPORCH  (V_FPORCH),
        .V_SYNC    (V_SYNC),
        .V_BPORCH  (V_BPORCH)
    ) u_timing (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .o_h_cnt       (w_h_cnt),
        .o_v_cnt       (w_v_cnt),
        .o_de          (w_de),
        .o_hs_act      (w_hs_act),
        .o_vs_act      (w_vs_act),
        .o_frame_start (w_frame_start),
        .o_frame_end   (w_frame_end)
    );

    // Mode is only sampled on the last pixel, so every frame sees one mode.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_active_mode <= '0;
            r_frame_cnt   <= '0;
        end else begin
            if (w_frame_end)
                r_active_mode <= bus.mode_i;
            if (w_frame_start)
                r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    always_comb begin
        w_raw      = '0;
        w_raw.de   = w_de;
        w_raw.hs   = w_hs_act;
        w_raw.vs   = w_vs_act;
        w_raw.mode = r_active_mode;
    end

    generate
        if (SRC_LAT == 0) begin : g_no_dly
            assign w_dly = w_raw;
        end else begin : g_dly
            stage_t r_pipe [SRC_LAT];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int i = 0; i < SRC_LAT; i++)
                        r_pipe[i] <= '0;
                end else begin
                    r_pipe[0] <= w_raw;
                    for (int i = 1; i < SRC_LAT; i++)
                        r_pipe[i] <= r_pipe[i-1];
                end
            end

            assign w_dly = r_pipe[SRC_LAT-1];
        end
    endgenerate

    always_comb begin
        w_pix = '0;
        if (w_dly.de) begin
            if (int'(w_dly.mode) > N_SRC)
                w_pix = '1;
            for (int k = 0; k < N_SRC; k++) begin
                if (int'(w_dly.mode) == k + MODE_SRC0)
                    w_pix = bus.src_data_i[k*c_PIX_BITS +: c_PIX_BITS];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rgb <= '0;
            r_hs  <= ~HS_POL;
            r_vs  <= ~VS_POL;
        end else begin
            r_rgb <= w_pix;
            r_hs  <= w_dly.hs ? HS_POL : ~HS_POL;
            r_vs  <= w_dly.vs ? VS_POL : ~VS_POL;
        end
    end

    assign bus.pix_x_o       = w_h_cnt;
    assign bus.pix_y_o       = w_v_cnt;
    assign bus.pix_de_o      = w_de;
    assign bus.frame_start_o = w_frame_start;
    assign bus.vga_hs_o      = r_hs;
    assign bus.vga_vs_o      = r_vs;
    assign bus.vga_r_o       = r_rgb[COLOR_W-1:0];
    assign bus.vga_g_o       = r_rgb[2*COLOR_W-1:COLOR_W];
    assign bus.vga_b_o       = r_rgb[3*COLOR_W-1:2*COLOR_W];
    assign bus.active_mode_o = r_active_mode;
    assign bus.frame_cnt_o   = r_frame_cnt;

endmodule
`default_nettype wire

// File: doc/vga_mode_ctrl.md
VGA_MODE_CTRL -- requirements
Module: vga_mode_ctrl

Interface
REQ-001 SHALL have parameter PIX_WIDTH, default 12, width of pixel coordinates.
REQ-002 SHALL have parameter COLOR_W, default 1, bits per colour channel.
REQ-003 SHALL have parameter N_SRC, default 2, number of pixel sources.
REQ-004 SHALL have parameter SRC_LAT, default 2, source latency in cycles from coordinates to data (>=0).
REQ-005 SHALL have parameters H_DISP/H_FPORCH/H_SYNC/H_BPORCH, defaults 640/16/96/48, horizontal timing.
REQ-006 SHALL have parameters V_DISP/V_FPORCH/V_SYNC/V_BPORCH, defaults 480/10/2/33, vertical timing.
REQ-007 SHALL have parameters HS_POL and VS_POL, default 0, active sync level.
REQ-008 SHALL have port clk_i, input, 1, pixel clock; one clock domain only.
REQ-009 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-010 SHALL have port mode_i, input, MODE_W=$clog2(N_SRC+2), requested mode: 0 black, 1..N_SRC source k-1, otherwise white.
REQ-011 SHALL have port src_data_i, input, N_SRC*3*COLOR_W, source k RGB at slice k, with order {b,g,r}.
REQ-012 SHALL have ports pix_x_o and pix_y_o, output, PIX_WIDTH, current counter coordinates sent to the sources.
REQ-013 SHALL have ports pix_de_o and frame_start_o, output, 1: counter in active area; counter at (0,0).
REQ-014 SHALL have ports vga_hs_o and vga_vs_o, output, 1, aligned syncs.
REQ-015 SHALL have ports vga_r_o, vga_g_o and vga_b_o, output, COLOR_W, registered colour.
REQ-016 SHALL have ports active_mode_o (MODE_W) and frame_cnt_o (16), output: latched mode; frame count.

Function
REQ-017 h_cnt SHALL run 0..H_TOTAL-1 and wrap to 0; v_cnt SHALL increment on each h wrap and wrap to 0 after V_TOTAL-1 (TOTAL = sum of the four parameters).
REQ-018 pix_x_o/pix_y_o SHALL equal h_cnt/v_cnt; pix_de_o SHALL be high iff h_cnt<H_DISP and v_cnt<V_DISP.
REQ-019 Raw hs SHALL be at HS_POL for h_cnt in [H_DISP+H_FPORCH, H_DISP+H_FPORCH+H_SYNC); vs likewise on v_cnt with VS_POL.
REQ-020 active_mode_o SHALL capture mode_i only on the cycle where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, so modes change on frame boundaries only.
REQ-021 frame_start_o SHALL be high for exactly the one cycle with counters at (0,0); frame_cnt_o SHALL increment on it and wrap at 0xFFFF->0.
REQ-022 de, hs, vs and the latched mode SHALL pass through a SRC_LAT-stage delay line, then one output register; total latency from counter to pins SHALL be SRC_LAT+1.
REQ-023 Pixel select SHALL use the delayed mode: 0 -> all zero; 1..N_SRC -> matching src_data_i slice; out of range -> all ones.
REQ-024 Colour SHALL be forced to 0 whenever delayed de is low.
REQ-025 A mode_i change mid-frame SHALL NOT alter any output pixel of that frame.

Reset
REQ-026 During rst_i, counters, frame_cnt_o, active_mode_o and all delay stages SHALL clear to 0.
REQ-027 Synchronous reset SHALL force colour to 0 and hs/vs to inactive level (~HS_POL/~VS_POL).
REQ-028 The first cycle after rst_i falls SHALL present counters at (0,0) with frame_start_o=1; frame_cnt_o reads 1 after that cycle.
REQ-029 Reset mid-frame SHALL abandon the frame with no partial sync pulse after release.

Structure
REQ-030 Shared package vga_pkg SHALL hold mode encodings (MODE_BLACK=0, MODE_SRC0=1) and the default 640x480 timing constants.
REQ-031 Counters plus raw sync/de generation SHALL be sub-module vga_timing_cnt; delay line and mux stay in vga_mode_ctrl.

Verification
REQ-032 H=8/2/2/2, V=4/1/1/1, SRC_LAT=2, run 2 frames -> hs low 2 cycles per 14-cycle line; vs low for one 14-cycle line per 7-line frame; pins lag counters 3 cycles.
REQ-033 mode_i=1, source 0 returns {b,g,r}=pix_x[2:0] -> visible pixel n shows n, blanking shows 0.
REQ-034 mode_i 1->2 at pixel (3,2) -> the current frame stays source 0; the change takes effect at first pixel of next frame, active_mode_o=2.
REQ-035 mode_i=3 with N_SRC=2 -> all active pixels 1 and blanking 0; mode_i=0 -> all pixels 0.
REQ-036 Assert rst_i at (5,2) for 3 cycles -> outputs 0 and syncs inactive; next cycle counters (0,0), frame_start_o=1, frame_cnt_o=1 after that cycle.
REQ-037 Preload frame_cnt_o to 0xFFFF via 65535 frames (small timing) -> next frame_start_o gives 0x0000.
